// File: rtl/branch_predict_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : branch_predict_unit_if
// Brief    : Fetch-prediction, EX-resolution and redirect bundle for the
//            branch predictor. The pipeline is master, the predictor is slave.
// Revision : 1.0
// ============================================================================
interface branch_predict_unit_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] f_pc;
  logic            f_pred_taken;
  logic            e_valid;
  logic [XLEN-1:0] e_pc;
  logic            e_br_out;
  logic            e_pred_taken;
  logic [XLEN-1:0] e_target;
  logic [XLEN-1:0] e_pc_plus4;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            flush;
  logic [31:0]     br_count;
  logic [31:0]     miss_count;

  modport master (
    output f_pc, e_valid, e_pc, e_br_out, e_pred_taken, e_target, e_pc_plus4,
    input  f_pred_taken, redirect, redirect_pc, flush, br_count, miss_count
  );

  modport slave (
    input  f_pc, e_valid, e_pc, e_br_out, e_pred_taken, e_target, e_pc_plus4,
    output f_pred_taken, redirect, redirect_pc, flush, br_count, miss_count
  );
endinterface
`default_nettype wire

// File: rtl/branch_predict_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_predict_unit
// Brief    : 2-bit saturating-counter branch predictor with EX-stage training,
//            registered mispredict redirect/flush and saturating statistics.
// Revision : 1.0
// ============================================================================
module branch_predict_unit #(
  parameter int INDEX_BITS = 6,
  parameter int XLEN       = 32
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  branch_predict_unit_if.slave  bp
);
  localparam int         C_ENTRIES  = 1 << INDEX_BITS;
  localparam logic [1:0] C_WEAK_NT  = 2'b01;
  localparam logic [1:0] C_STRONG_T = 2'b11;
  localparam logic [1:0] C_STRONG_N = 2'b00;
  localparam logic [31:0] C_CNT_MAX = 32'hFFFF_FFFF;

  logic [1:0]            r_table [C_ENTRIES];
  logic                  r_redirect;
  logic [XLEN-1:0]       r_redirect_pc;
  logic [31:0]           r_br_count;
  logic [31:0]           r_miss_count;

  logic [INDEX_BITS-1:0] w_f_idx;
  logic [INDEX_BITS-1:0] w_e_idx;
  logic [1:0]            w_cur_ctr;
  logic [1:0]            w_next_ctr;
  logic                  w_accept;
  logic                  w_mispredict;
  logic                  w_unused;

  assign w_f_idx   = bp.f_pc[INDEX_BITS+1:2];
  assign w_e_idx   = bp.e_pc[INDEX_BITS+1:2];
  assign w_cur_ctr = r_table[w_e_idx];

  // The EX instruction behind a redirect is on the wrong path and is dropped.
  assign w_accept     = bp.e_valid & ~r_redirect;
  assign w_mispredict = w_accept & (bp.e_br_out != bp.e_pred_taken);

  assign w_unused = ^{bp.f_pc[XLEN-1:INDEX_BITS+2], bp.f_pc[1:0],
                      bp.e_pc[XLEN-1:INDEX_BITS+2], bp.e_pc[1:0]};

  always_comb begin
    w_next_ctr = w_cur_ctr;
    if (bp.e_br_out) begin
      if (w_cur_ctr != C_STRONG_T) w_next_ctr = w_cur_ctr + 2'd1;
    end else begin
      if (w_cur_ctr != C_STRONG_N) w_next_ctr = w_cur_ctr - 2'd1;
    end
  end

  // Read port is the raw table: same-entry updates show up next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < C_ENTRIES; i++) r_table[i] <= C_WEAK_NT;
    end else if (w_accept) begin
      r_table[w_e_idx] <= w_next_ctr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      r_redirect <= w_mispredict;
      if (w_mispredict) begin
        r_redirect_pc <= bp.e_br_out ? bp.e_target : bp.e_pc_plus4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_br_count   <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_accept && (r_br_count != C_CNT_MAX)) begin
        r_br_count <= r_br_count + 32'd1;
      end
      if (w_mispredict && (r_miss_count != C_CNT_MAX)) begin
        r_miss_count <= r_miss_count + 32'd1;
      end
    end
  end

  assign bp.f_pred_taken = r_table[w_f_idx][1];
  assign bp.redirect     = r_redirect;
  assign bp.flush        = r_redirect;
  assign bp.redirect_pc  = r_redirect_pc;
  assign bp.br_count     = r_br_count;
  assign bp.miss_count   = r_miss_count;
endmodule
`default_nettype wire

// File: doc/branch_predict_unit.md
# branch_predict_unit

Dynamic branch predictor and resolution unit for the RV32I pipeline. It predicts conditional branches at fetch using a table of 2-bit saturating counters. At execute it takes the resolved outcome from the branch compare unit (BrOut), trains the table, and on a mispredict issues a registered one-cycle redirect and flush to fetch. It also keeps saturating branch and mispredict counters for performance monitoring.

## Interface
Parameters:
- INDEX_BITS, 6, log2 of table entries (64 entries); index = PC[INDEX_BITS+1:2]
- XLEN, 32, address width

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RST_N  in  1  asynchronous, active-low reset
- F_PC  in  XLEN  fetch-stage PC to predict
- F_PredTaken  out  1  combinational prediction for F_PC: counter[F_PC index][1]
- E_Valid  in  1  a conditional branch is resolving in EX this cycle
- E_PC  in  XLEN  PC of the resolving branch
- E_BrOut  in  1  actual outcome from the branch compare unit (1 = taken)
- E_PredTaken  in  1  the prediction made for this branch at fetch, carried down the pipeline
- E_Target  in  XLEN  branch target (PC + imm)
- E_PCPlus4  in  XLEN  fall-through address
- Redirect  out  1  registered one-cycle pulse: fetch must load RedirectPC
- RedirectPC  out  XLEN  registered corrected PC; valid when Redirect = 1
- Flush  out  1  equal to Redirect; squashes IF/ID and ID/EX contents
- BrCount  out  32  number of branches resolved, saturating
- MissCount  out  32  number of mispredicts, saturating

## Operation
- **Table.** 2^INDEX_BITS entries of 2-bit counters. Encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Prediction is the counter's MSB.
- **Accepted resolve.** A resolve is accepted when E_Valid = 1 and Redirect = 0.
  - When Redirect = 1, the EX instruction is on the wrong path. E_Valid is ignored: no training, no counting, no new redirect.
- **Training** on an accepted resolve, at index E_PC[INDEX_BITS+1:2]:
  - E_BrOut = 1: counter = min(counter + 1, 3).
  - E_BrOut = 0: counter = max(counter − 1, 0).
- **Mispredict** = accepted resolve with E_BrOut != E_PredTaken. On the next edge:
  - Redirect ← 1.
  - RedirectPC ← E_Target if E_BrOut = 1, else E_PCPlus4.
  - Otherwise Redirect ← 0. RedirectPC holds its last value.
- **Statistics.** Each accepted resolve increments BrCount. Each mispredict increments MissCount. Both stick at 32'hFFFF_FFFF.
- **Read/write same entry.** When F_PC and E_PC map to the same entry in one cycle, F_PredTaken shows the pre-update counter. There is no bypass.
- **Aliasing.** PCs that differ only above bit INDEX_BITS+1 share an entry, by design.
- **Reset.** Asynchronous. RST_N low immediately forces:
  - every counter = 01;
  - Redirect = 0, Flush = 0, RedirectPC = 0;
  - BrCount = 0, MissCount = 0.
  
  F_PredTaken therefore reads 0 for every PC. Reset asserted mid-operation drops any pending redirect. State resumes on the first rising edge after RST_N goes high.

## Timing
- F_PredTaken: combinational from F_PC, same cycle.
- Counter update: visible to F_PredTaken in the cycle after the accepted resolve edge.
- Redirect/Flush: asserted exactly one cycle after the mispredicting resolve, for exactly one cycle. Back-to-back redirects cannot occur, because resolves during Redirect are ignored.
- BrCount/MissCount: update on the same edge as training.

## Test plan
- **Reset.** Drive RST_N = 0 between edges. Required: outputs clear immediately. After release, F_PC = 0x100 gives F_PredTaken = 0, and BrCount = MissCount = 0.
- **Saturation up.** Four accepted resolves at E_PC = 0x40, E_BrOut = 1, E_PredTaken matching the current prediction. Required:
  - entry goes 01→10→11→11;
  - F_PredTaken(0x40) = 1 from the cycle after the first update;
  - the first resolve mispredicts (PredTaken 0) and redirects to E_Target;
  - BrCount = 4, MissCount = 1.
- **Mispredict not-taken.** Entry strong-T, resolve E_PC = 0x80, E_BrOut = 0, E_PredTaken = 1, E_PCPlus4 = 0x84. Required: next cycle Redirect = Flush = 1 and RedirectPC = 0x84. The following cycle Redirect = 0. Entry becomes 10.
- **Wrong-path squash.** In the Redirect = 1 cycle, drive E_Valid = 1 with a mispredicting outcome. Required: no counter change, no BrCount/MissCount change, and Redirect = 0 in the next cycle.
- **Same-entry collision.** F_PC = E_PC = 0x200 in one cycle, entry 01, E_BrOut = 1. Required: F_PredTaken = 0 that cycle and 1 in the next cycle.
- **Aliasing and counter saturation.**
  - PCs 0x004 and 0x104 (INDEX_BITS = 6) share an entry: training one changes the other's prediction.
  - Forcing MissCount to 32'hFFFF_FFFF and then causing a mispredict leaves it at 32'hFFFF_FFFF.
